// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Purpose  : Shared types and constants for the memory port arbiter:
//             FSM state encoding, requester owner encoding and default
//             address/data widths.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int c_ADDR_W = 8;
    localparam int c_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // Owner of the access currently in flight.
    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pick
//  Purpose  : Combinational winner select between fetch and MEM-stage
//             requests. The result is only meaningful when at least one
//             request is present.
//  Config   : MEM_PORT_ARB_RR_EN - ties alternate (the requester that did
//             not win last time wins). Undefined: MEM always beats fetch.
//  Ports    : i_if_req       fetch request
//             i_mem_req      MEM-stage request (read or write)
//             i_last_winner  owner of the previous grant
//             o_owner        granted owner (OWN_IF / OWN_MEM)
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_if_req,
    input  logic i_mem_req,
    input  logic i_last_winner,
    output logic o_owner
);

`ifdef MEM_PORT_ARB_RR_EN
    always_comb begin
        if (i_if_req && i_mem_req) begin
            o_owner = ~i_last_winner;
        end else if (i_mem_req) begin
            o_owner = OWN_MEM;
        end else begin
            o_owner = OWN_IF;
        end
    end
`else
    // Fixed priority: the older instruction in MEM always wins, so the
    // fetch request and the history input do not affect the choice.
    logic [1:0] w_unused_pick;
    assign w_unused_pick = {i_if_req, i_last_winner};

    always_comb begin
        o_owner = i_mem_req ? OWN_MEM : OWN_IF;
    end
`endif

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one fixed-latency single-port memory between the fetch
//             stage and the MEM stage. Each access runs IDLE -> ISSUE ->
//             (WAIT) -> RESP and occupies MEM_LATENCY+2 cycles.
//  Config   : MEM_PORT_ARB_RR_EN - round-robin tie break (see mem_arb_pick)
//  Ports    : clk, rst               clock / sync active-high reset
//             if_req/if_addr         fetch read request
//             if_ready/if_rdata      fetch completion pulse and data
//             mem_read/mem_write     MEM-stage request (both high = write)
//             mem_addr/mem_wdata     MEM-stage address and store data
//             mem_ready/mem_rdata    MEM-stage completion pulse and data
//             stall_if/stall_mem     combinational stalls to hazard unit
//             m_en/m_we/m_addr/
//             m_wdata/m_rdata        memory-side port
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = 2,
    parameter int ADDR_W      = c_ADDR_W,
    parameter int DATA_W      = c_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ready,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam int              CNT_W      = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    arb_state_t        r_state_q, w_state_d;
    logic              r_owner_q, w_owner_d;
    logic              r_we_q,    w_we_d;
    logic [ADDR_W-1:0] r_addr_q,  w_addr_d;
    logic [DATA_W-1:0] r_wdata_q, w_wdata_d;
    logic [CNT_W-1:0]  r_cnt_q,   w_cnt_d;

    logic w_mem_req;
    logic w_any_req;
    logic w_grant;
    logic w_last_winner;

    assign w_mem_req = mem_read | mem_write;
    assign w_any_req = if_req | w_mem_req;

`ifdef MEM_PORT_ARB_RR_EN
    logic r_last_q, w_last_d;
    assign w_last_winner = r_last_q;
`else
    assign w_last_winner = OWN_MEM;
`endif

    mem_arb_pick u_pick (
        .i_if_req      (if_req),
        .i_mem_req     (w_mem_req),
        .i_last_winner (w_last_winner),
        .o_owner       (w_grant)
    );

    always_comb begin
        w_state_d = r_state_q;
        w_owner_d = r_owner_q;
        w_we_d    = r_we_q;
        w_addr_d  = r_addr_q;
        w_wdata_d = r_wdata_q;
        w_cnt_d   = r_cnt_q;
`ifdef MEM_PORT_ARB_RR_EN
        w_last_d  = r_last_q;
`endif
        if_ready  = 1'b0;
        if_rdata  = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;

        case (r_state_q)
            IDLE: begin
                if (w_any_req) begin
                    w_owner_d = w_grant;
                    w_state_d = ISSUE;
                    if (w_grant == OWN_MEM) begin
                        w_addr_d  = mem_addr;
                        w_wdata_d = mem_wdata;
                        // read+write together is treated as a write
                        w_we_d    = mem_write;
                    end else begin
                        w_addr_d  = if_addr;
                        w_wdata_d = '0;
                        w_we_d    = 1'b0;
                    end
`ifdef MEM_PORT_ARB_RR_EN
                    w_last_d  = w_grant;
`endif
                end
            end
            ISSUE: begin
                w_cnt_d   = c_CNT_LOAD;
                w_state_d = (MEM_LATENCY == 1) ? RESP : WAIT;
            end
            WAIT: begin
                if (r_cnt_q != '0) begin
                    w_cnt_d = r_cnt_q - c_CNT_ONE;
                end
                if (r_cnt_q == c_CNT_ONE) begin
                    w_state_d = RESP;
                end
            end
            RESP: begin
                w_state_d = IDLE;
                // A requester that withdrew gets no pulse; the access
                // itself (including a write) has already been committed.
                if (r_owner_q == OWN_MEM) begin
                    if (w_mem_req) begin
                        mem_ready = 1'b1;
                        mem_rdata = r_we_q ? '0 : m_rdata;
                    end
                end else if (if_req) begin
                    if_ready = 1'b1;
                    if_rdata = m_rdata;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= IDLE;
            r_owner_q <= OWN_IF;
            r_we_q    <= 1'b0;
            r_addr_q  <= '0;
            r_wdata_q <= '0;
            r_cnt_q   <= '0;
`ifdef MEM_PORT_ARB_RR_EN
            r_last_q  <= OWN_MEM;
`endif
        end else begin
            r_state_q <= w_state_d;
            r_owner_q <= w_owner_d;
            r_we_q    <= w_we_d;
            r_addr_q  <= w_addr_d;
            r_wdata_q <= w_wdata_d;
            r_cnt_q   <= w_cnt_d;
`ifdef MEM_PORT_ARB_RR_EN
            r_last_q  <= w_last_d;
`endif
        end
    end

    assign m_en      = (r_state_q == ISSUE);
    assign m_we      = m_en & r_we_q;
    assign m_addr    = r_addr_q;
    assign m_wdata   = r_wdata_q;
    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = w_mem_req & ~mem_ready;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Self-checking bench for mem_port_arbiter. A fixed-latency
//             memory model serves the DUT; expected behaviour is computed
//             per transaction from the access schedule (issue at start+1,
//             ready at start+1+L, next access at start+L+2).
//  Config   : MEM_PORT_ARB_RR_EN - selects the round-robin expectation
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int L = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       if_req;
    logic [7:0] if_addr;
    logic       if_ready;
    logic [7:0] if_rdata;
    logic       mem_read;
    logic       mem_write;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_ready;
    logic [7:0] mem_rdata;
    logic       stall_if;
    logic       stall_mem;
    logic       m_en;
    logic       m_we;
    logic [7:0] m_addr;
    logic [7:0] m_wdata;
    logic [7:0] m_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .MEM_LATENCY (L),
        .ADDR_W      (8),
        .DATA_W      (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ready  (if_ready),
        .if_rdata  (if_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .m_en      (m_en),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata)
    );

    function automatic logic [7:0] init_val(input int i);
        return 8'((i * 37 + 5) & 255);
    endfunction

    // ---------------- memory model (stimulus side) ----------------
    logic [7:0] mem_arr [256];
    logic       mem_init_done = 1'b0;
    logic       pipe_v [L] = '{default: 1'b0};
    logic [7:0] pipe_d [L] = '{default: 8'h00};
    logic       ff_mode = 1'b0;

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= init_val(i);
            mem_init_done <= 1'b1;
        end else if (m_en && m_we) begin
            mem_arr[m_addr] <= m_wdata;
        end
        pipe_v[0] <= m_en && !m_we;
        pipe_d[0] <= mem_arr[m_addr];
        for (int k = 1; k < L; k++) begin
            pipe_v[k] <= pipe_v[k-1];
            pipe_d[k] <= pipe_d[k-1];
        end
    end

    // Junk value outside the valid window so ungated data paths show up.
    assign m_rdata = pipe_v[L-1] ? (ff_mode ? 8'hFF : pipe_d[L-1]) : 8'hEE;

    // ---------------- reference state ----------------
    logic [7:0] ref_mem [256];
    logic       last_win;
    int         checks   = 0;
    int         failures = 0;
    int         cur_cycle = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cur_cycle, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cur_cycle++;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        if_req = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        step(); step();
        rst = 1'b0;
        last_win = 1'b1;
    endtask

    // One scenario starting in IDLE. mop: 0 none, 1 read, 2 write, 3 both.
    // *_drop: relative cycle at which the request is withdrawn (-1: at ready+1).
    task automatic run_scn(input bit have_if, input logic [7:0] ia, input int mop,
                           input logic [7:0] ma, input logic [7:0] wd,
                           input int if_drop, input int mem_drop);
        bit         have_mem;
        bit         mem_wr;
        int         n;
        bit         own [2];
        int         s_if, s_mem, rdy_if, rdy_mem, if_off, mem_off, end_c;
        logic [7:0] d_if, d_mem;
        bit         mem_first;
        have_mem = (mop != 0);
        mem_wr   = (mop >= 2);
        n = 0;
        s_if = -100; s_mem = -100; d_if = 8'h00; d_mem = 8'h00;
        if (have_if && have_mem) begin
`ifdef MEM_PORT_ARB_RR_EN
            mem_first = (last_win == 1'b0);
`else
            mem_first = 1'b1;
`endif
            own[0] = mem_first; own[1] = !mem_first; n = 2;
        end else if (have_mem) begin
            own[0] = 1'b1; n = 1;
        end else if (have_if) begin
            own[0] = 1'b0; n = 1;
        end
        for (int k = 0; k < n; k++) begin
            if (own[k]) begin
                s_mem = k * (L + 2);
                if (mem_wr) ref_mem[ma] = wd;
                else        d_mem = ref_mem[ma];
            end else begin
                s_if = k * (L + 2);
                d_if = ref_mem[ia];
            end
            last_win = own[k];
        end
        rdy_if  = s_if + 1 + L;
        rdy_mem = s_mem + 1 + L;
        if_off  = (if_drop  >= 0) ? if_drop  : rdy_if + 1;
        mem_off = (mem_drop >= 0) ? mem_drop : rdy_mem + 1;
        end_c   = (n == 0) ? 0 : (n - 1) * (L + 2) + L + 2;
        for (int c = 0; c <= end_c; c++) begin
            bit e_men, e_we, e_ifr, e_memr, rq_if, rq_mem;
            logic [7:0] e_addr, e_wd, e_ifd, e_memd;
            rq_if     = have_if  && (c < if_off);
            rq_mem    = have_mem && (c < mem_off);
            if_req    = rq_if;
            if_addr   = ia;
            mem_read  = rq_mem && (mop == 1 || mop == 3);
            mem_write = rq_mem && mem_wr;
            mem_addr  = ma;
            mem_wdata = wd;
            #1;
            e_men = 1'b0; e_we = 1'b0; e_addr = 8'h00; e_wd = 8'h00;
            if (c == s_if + 1)  begin e_men = 1'b1; e_addr = ia; end
            if (c == s_mem + 1) begin e_men = 1'b1; e_addr = ma; e_we = mem_wr; e_wd = wd; end
            e_ifr  = rq_if  && (c == rdy_if);
            e_memr = rq_mem && (c == rdy_mem);
            e_ifd  = e_ifr ? d_if : 8'h00;
            e_memd = (e_memr && !mem_wr) ? d_mem : 8'h00;
            chk("m_en", 32'(m_en), 32'(e_men));
            if (e_men) begin
                chk("m_we",   32'(m_we),   32'(e_we));
                chk("m_addr", 32'(m_addr), 32'(e_addr));
                if (e_we) chk("m_wdata", 32'(m_wdata), 32'(e_wd));
            end
            chk("if_ready",  32'(if_ready),  32'(e_ifr));
            chk("if_rdata",  32'(if_rdata),  32'(e_ifd));
            chk("mem_ready", 32'(mem_ready), 32'(e_memr));
            chk("mem_rdata", 32'(mem_rdata), 32'(e_memd));
            chk("stall_if",  32'(stall_if),  32'(rq_if  && !e_ifr));
            chk("stall_mem", 32'(stall_mem), 32'(rq_mem && !e_memr));
            step();
        end
        if_req = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        rst = 1'b1; if_req = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        if_addr = 8'h00; mem_addr = 8'h00; mem_wdata = 8'h00;
        last_win = 1'b1;
        #1;
        reset_dut();
        step();

        // reset state
        #1;
        chk("rst_m_en",      32'(m_en),      32'd0);
        chk("rst_m_we",      32'(m_we),      32'd0);
        chk("rst_m_addr",    32'(m_addr),    32'd0);
        chk("rst_m_wdata",   32'(m_wdata),   32'd0);
        chk("rst_if_ready",  32'(if_ready),  32'd0);
        chk("rst_mem_ready", 32'(mem_ready), 32'd0);
        chk("rst_if_rdata",  32'(if_rdata),  32'd0);
        chk("rst_mem_rdata", 32'(mem_rdata), 32'd0);
        chk("rst_stall_if",  32'(stall_if),  32'd0);
        chk("rst_stall_mem", 32'(stall_mem), 32'd0);
        step();

        // write then fetch read of the same word
        run_scn(1'b0, 8'h00, 2, 8'h10, 8'hA5, -1, -1);
        run_scn(1'b1, 8'h10, 0, 8'h00, 8'h00, -1, -1);
        // store, and read+write together behaves as a write
        run_scn(1'b0, 8'h00, 2, 8'h7F, 8'h44, -1, -1);
        run_scn(1'b0, 8'h00, 3, 8'h7F, 8'h55, -1, -1);
        run_scn(1'b0, 8'h00, 1, 8'h7F, 8'h00, -1, -1);
        // tie
        run_scn(1'b1, 8'h20, 1, 8'h80, 8'h00, -1, -1);
        // requester withdraws during WAIT: read, then write (still committed)
        run_scn(1'b0, 8'h00, 1, 8'h40, 8'h00, -1, 2);
        run_scn(1'b0, 8'h00, 2, 8'h41, 8'h99, -1, 2);
        run_scn(1'b1, 8'h41, 0, 8'h00, 8'h00, -1, -1);

        // reset during WAIT; memory's late data must be ignored
        if_req = 1'b1; if_addr = 8'h33;
        #1;
        chk("mid_stall_if", 32'(stall_if), 32'd1);
        step(); #1;
        chk("mid_m_en_issue", 32'(m_en),   32'd1);
        chk("mid_m_addr",     32'(m_addr), 32'h33);
        step();
        rst = 1'b1; ff_mode = 1'b1;
        step();
        rst = 1'b0; last_win = 1'b1;
        #1;
        chk("mid_m_en_after",   32'(m_en),     32'd0);
        chk("mid_if_ready",     32'(if_ready), 32'd0);
        chk("mid_if_rdata",     32'(if_rdata), 32'd0);
        ff_mode = 1'b0;
        run_scn(1'b1, 8'h33, 0, 8'h00, 8'h00, -1, -1);

        // two successive ties straight after reset
        reset_dut();
        run_scn(1'b1, 8'h21, 1, 8'h81, 8'h00, -1, -1);
        run_scn(1'b1, 8'h22, 2, 8'h21, 8'h6C, -1, -1);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            bit         hi;
            int         op;
            logic [7:0] a1, a2, d;
            hi = 1'($urandom_range(0, 1));
            op = $urandom_range(0, 3);
            a1 = 8'($urandom_range(0, 15)) | 8'hC0;
            a2 = 8'($urandom_range(0, 15)) | 8'hC0;
            d  = 8'($urandom_range(0, 255));
            run_scn(hi, a1, op, a2, d, -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
